// File: rtl/tv_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tv_recorder
// Description : Captures one vector word per qualified cycle into on-chip
//               storage, then replays the words in capture order over a
//               valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tv_recorder #(
    parameter int VEC_W  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              vec_valid,
    input  logic [VEC_W-1:0]  vec_in,
    input  logic              dump,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [VEC_W-1:0]  out_vec,
    output logic              out_last,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DUMP   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_last_slot = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_one       = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_zero = '0;

    state_t            r_state;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic              r_out_valid;
    logic [VEC_W-1:0]  r_out_vec;
    logic              r_out_last;
    logic              r_busy;
    logic              r_full;
    logic [VEC_W-1:0]  r_mem [DEPTH];

    logic              w_wr;
    logic              w_fill_last;
    logic [ADDR_W-1:0] w_rptr_inc;
    logic [ADDR_W:0]   w_last_idx;

    // A restart in the same cycle discards the word; a full store drops it.
    assign w_fill_last = (r_count == c_last_slot);
    assign w_wr        = (r_state == ST_RECORD) && !start && vec_valid && (r_count != c_depth);
    assign w_rptr_inc  = r_rptr + 1'b1;
    assign w_last_idx  = r_count - c_one;

    // Storage is deliberately not reset; count==0 marks it empty.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= vec_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        r_wptr  <= '0;
                        r_full  <= 1'b0;
                        r_state <= ST_RECORD;
                        r_busy  <= 1'b1;
                    end else if (dump && (r_count != '0)) begin
                        // First word is presented on the cycle after entry.
                        r_rptr      <= '0;
                        r_out_valid <= 1'b1;
                        r_out_vec   <= r_mem[c_addr_zero];
                        r_out_last  <= (r_count == c_one);
                        r_state     <= ST_DUMP;
                        r_busy      <= 1'b1;
                    end
                end

                ST_RECORD: begin
                    if (start) begin
                        r_count <= '0;
                        r_wptr  <= '0;
                        r_full  <= 1'b0;
                    end else begin
                        if (w_wr) begin
                            // Hold wptr on the final slot so it never wraps.
                            r_wptr  <= w_fill_last ? r_wptr : (r_wptr + 1'b1);
                            r_count <= r_count + c_one;
                            r_full  <= w_fill_last;
                        end
                        if (stop || (w_wr && w_fill_last)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                ST_DUMP: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_rptr     <= w_rptr_inc;
                            r_out_vec  <= r_mem[w_rptr_inc];
                            r_out_last <= ({1'b0, w_rptr_inc} == w_last_idx);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign full      = r_full;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_tv_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tv_recorder
// Description : Directed self-checking bench for tv_recorder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tv_recorder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec_in = '0;
    logic       dump = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_vec;
    logic       out_last;
    logic       busy;
    logic       full;
    logic [4:0] count;

    int n_total = 0;
    int n_pass  = 0;

    logic [3:0] bq_vec[$];
    logic       bq_last[$];

    tv_recorder #(.VEC_W(4), .DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .vec_valid (vec_valid),
        .vec_in    (vec_in),
        .dump      (dump),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_vec   (out_vec),
        .out_last  (out_last),
        .busy      (busy),
        .full      (full),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record_words(input logic [3:0] w [4], input int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            vec_valid = 1'b1;
            vec_in    = w[i];
            tick();
        end
        vec_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Streams one dump with out_ready held high, logging each transferred beat.
    task automatic collect(input int limit, output bit timed_out);
        bq_vec.delete();
        bq_last.delete();
        timed_out = 1'b1;
        out_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (out_valid) begin
                bq_vec.push_back(out_vec);
                bq_last.push_back(out_last);
                if (out_last) begin
                    tick();
                    timed_out = 1'b0;
                    break;
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_total++; if (out_vec !== 4'h0) $display("FAIL reset_out_vec got %h exp 0", out_vec); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] w [4] = '{4'h3, 4'hA, 4'h5, 4'h0};
        record_words(w, 3);
        n_total++; if (count !== 5'd3) $display("FAIL basic_count got %0d exp 3", count); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_idle got %b exp 0", busy); else n_pass++;
        out_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        n_total++; if ({out_valid, out_vec, out_last} !== {1'b1, 4'h3, 1'b0}) $display("FAIL basic_beat0 got v%b %h l%b exp v1 3 l0", out_valid, out_vec, out_last); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_dump got %b exp 1", busy); else n_pass++;
        tick();
        n_total++; if ({out_valid, out_vec, out_last} !== {1'b1, 4'hA, 1'b0}) $display("FAIL basic_beat1 got v%b %h l%b exp v1 a l0", out_valid, out_vec, out_last); else n_pass++;
        tick();
        n_total++; if ({out_valid, out_vec, out_last} !== {1'b1, 4'h5, 1'b1}) $display("FAIL basic_beat2 got v%b %h l%b exp v1 5 l1", out_valid, out_vec, out_last); else n_pass++;
        tick();
        n_total++; if ({out_valid, out_last, busy} !== 3'b000) $display("FAIL basic_end got v%b l%b b%b exp 000", out_valid, out_last, busy); else n_pass++;
        n_total++; if (count !== 5'd3) $display("FAIL basic_count_kept got %0d exp 3", count); else n_pass++;
    endtask

    task automatic test_full();
        bit to;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vec_valid = 1'b1;
            vec_in    = 4'(i);
            tick();
            if (i == 15) begin
                n_total++; if ({count, full, busy} !== {5'd16, 1'b1, 1'b0}) $display("FAIL full_at16 got c%0d f%b b%b exp c16 f1 b0", count, full, busy); else n_pass++;
            end
        end
        vec_valid = 1'b0;
        n_total++; if (count !== 5'd16) $display("FAIL full_count_after_drop got %0d exp 16", count); else n_pass++;
        collect(40, to);
        n_total++; if (to !== 1'b0) $display("FAIL full_dump_timeout got %b exp 0", to); else n_pass++;
        n_total++; if (bq_vec.size() !== 16) $display("FAIL full_beat_count got %0d exp 16", bq_vec.size()); else n_pass++;
        for (int i = 0; i < 16 && i < bq_vec.size(); i++) begin
            n_total++; if ({bq_vec[i], bq_last[i]} !== {4'(i), (i == 15)}) $display("FAIL full_beat%0d got %h l%b exp %h l%b", i, bq_vec[i], bq_last[i], 4'(i), (i == 15)); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] w [4] = '{4'hC, 4'hD, 4'hE, 4'h0};
        record_words(w, 3);
        out_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        n_total++; if ({out_valid, out_vec} !== {1'b1, 4'hC}) $display("FAIL bp_beat0 got v%b %h exp v1 c", out_valid, out_vec); else n_pass++;
        tick();
        out_ready = 1'b0;
        n_total++; if ({out_valid, out_vec, out_last} !== {1'b1, 4'hD, 1'b0}) $display("FAIL bp_beat1 got v%b %h l%b exp v1 d l0", out_valid, out_vec, out_last); else n_pass++;
        tick();
        n_total++; if ({out_valid, out_vec, out_last} !== {1'b1, 4'hD, 1'b0}) $display("FAIL bp_stall1 got v%b %h l%b exp v1 d l0", out_valid, out_vec, out_last); else n_pass++;
        tick();
        n_total++; if ({out_valid, out_vec, out_last} !== {1'b1, 4'hD, 1'b0}) $display("FAIL bp_stall2 got v%b %h l%b exp v1 d l0", out_valid, out_vec, out_last); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++; if ({out_valid, out_vec, out_last} !== {1'b1, 4'hE, 1'b1}) $display("FAIL bp_beat2 got v%b %h l%b exp v1 e l1", out_valid, out_vec, out_last); else n_pass++;
        tick();
        n_total++; if ({out_valid, busy} !== 2'b00) $display("FAIL bp_end got v%b b%b exp 00", out_valid, busy); else n_pass++;
    endtask

    task automatic test_empty_and_priority();
        logic [3:0] w [4] = '{4'h1, 4'h2, 4'h0, 4'h0};
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        dump = 1'b1;
        tick();
        dump = 1'b0;
        n_total++; if ({busy, out_valid} !== 2'b00) $display("FAIL empty_dump got b%b v%b exp 00", busy, out_valid); else n_pass++;
        tick();
        n_total++; if ({busy, out_valid} !== 2'b00) $display("FAIL empty_dump_late got b%b v%b exp 00", busy, out_valid); else n_pass++;
        record_words(w, 2);
        start = 1'b1;
        dump = 1'b1;
        tick();
        start = 1'b0;
        dump = 1'b0;
        n_total++; if ({busy, out_valid, count} !== {1'b1, 1'b0, 5'd0}) $display("FAIL start_dump_prio got b%b v%b c%0d exp b1 v0 c0", busy, out_valid, count); else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] w [4] = '{4'h3, 4'hA, 4'h5, 4'h0};
        record_words(w, 3);
        out_ready = 1'b0;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL areset_pre_valid got %b exp 1", out_valid); else n_pass++;
        #3;
        reset = 1'b0;
        #1;
        n_total++; if ({out_valid, out_vec, out_last, busy, count} !== {1'b0, 4'h0, 1'b0, 1'b0, 5'd0}) $display("FAIL areset_immediate got v%b %h l%b b%b c%0d exp all 0", out_valid, out_vec, out_last, busy, count); else n_pass++;
        #2;
        reset = 1'b1;
        tick();
        out_ready = 1'b1;
        dump = 1'b1;
        tick();
        dump = 1'b0;
        n_total++; if ({busy, out_valid} !== 2'b00) $display("FAIL areset_dump_ignored got b%b v%b exp 00", busy, out_valid); else n_pass++;
    endtask

    task automatic test_stop_capture_redump();
        bit to;
        logic [3:0] first_vec[$];
        start = 1'b1;
        tick();
        start = 1'b0;
        vec_valid = 1'b1;
        vec_in = 4'h9;
        tick();
        stop = 1'b1;
        vec_in = 4'h7;
        tick();
        stop = 1'b0;
        vec_valid = 1'b0;
        n_total++; if ({count, busy} !== {5'd2, 1'b0}) $display("FAIL stop_capture got c%0d b%b exp c2 b0", count, busy); else n_pass++;
        for (int pass = 0; pass < 2; pass++) begin
            collect(10, to);
            n_total++; if (to !== 1'b0) $display("FAIL redump%0d_timeout got %b exp 0", pass, to); else n_pass++;
            n_total++; if (bq_vec.size() !== 2) $display("FAIL redump%0d_beats got %0d exp 2", pass, bq_vec.size()); else n_pass++;
            if (bq_vec.size() == 2) begin
                n_total++; if ({bq_vec[0], bq_last[0], bq_vec[1], bq_last[1]} !== {4'h9, 1'b0, 4'h7, 1'b1}) $display("FAIL redump%0d_data got %h l%b %h l%b exp 9 l0 7 l1", pass, bq_vec[0], bq_last[0], bq_vec[1], bq_last[1]); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_backpressure();
        test_empty_and_priority();
        test_async_reset();
        test_stop_capture_redump();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
